cpu: RTL and testbench

//   Minimal 16-bit multi-cycle CPU with an internal unified word-addressed memory (mem).
//   Top-level compute block: the bench preloads mem through the hierarchical path
//   <inst>.mem, then releases reset. The core fetches, executes, and halts on HALT.

---
 rtl/cpu.sv | 135 +++++++++++++
 tb/tb_cpu.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// Minimal 16-bit multi-cycle CPU (FETCH -> EXEC) with an internal unified word memory.
// Optional define CPU_TRACE_EN prints an execution trace; RTL behaviour is unchanged by it.
module cpu #(
  parameter int MEMORY_SIZE = 32
) (
  input  logic clk,
  input  logic rst,
  output logic halted
);
  localparam int AW = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pc_inc, mem_a;
  logic [15:0]   ir_q, ir_d;
  logic [15:0]   r_q [4];
  logic [15:0]   r_d [4];
  logic          z_q, z_d, c_q, c_d;
  logic [15:0]   mem [0:MEMORY_SIZE-1];

  logic [3:0]    op;
  logic [1:0]    rd, rs;
  logic [7:0]    imm;
  logic [15:0]   a, b, res;
  logic [16:0]   sum;
  logic          mem_we;

  assign op     = ir_q[15:12];
  assign rd     = ir_q[11:10];
  assign rs     = ir_q[9:8];
  assign imm    = ir_q[7:0];
  assign mem_a  = imm[AW-1:0];
  assign a      = r_q[rd];
  assign b      = r_q[rs];
  assign sum    = {1'b0, a} + {1'b0, b};
  assign pc_inc = (pc_q == AW'(MEMORY_SIZE - 1)) ? '0 : pc_q + 1'b1;
  assign halted = (state_q == HALT);

  // Gating with rst keeps a store from landing on the same edge reset arrives.
  assign mem_we = rst && (state_q == EXEC) && (op == 4'h3);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    r_d     = r_q;
    z_d     = z_q;
    c_d     = c_q;
    res     = '0;
    case (state_q)
      FETCH: begin
        ir_d    = mem[pc_q];
        pc_d    = pc_inc;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        case (op)
          4'h1: r_d[rd] = {8'h00, imm};
          4'h2: begin
            r_d[rd] = mem[mem_a];
            z_d     = (mem[mem_a] == 16'h0000);
          end
          4'h4: r_d[rd] = b;
          4'h5: begin
            res = sum[15:0];
            c_d = sum[16];
          end
          4'h6: begin
            res = a - b;
            c_d = (a < b);
          end
          4'h7: res = a & b;
          4'h8: res = a | b;
          4'h9: res = a ^ b;
          4'hA: begin
            res = {a[14:0], 1'b0};
            c_d = a[15];
          end
          4'hB: begin
            res = {1'b0, a[15:1]};
            c_d = a[0];
          end
          4'hC: pc_d = imm[AW-1:0];
          4'hD: if (z_q) pc_d = imm[AW-1:0];
          4'hE: if (!z_q) pc_d = imm[AW-1:0];
          4'hF: state_d = HALT;
          default: ;
        endcase
        // ALU group 5..B shares the writeback and zero-flag update.
        if (op >= 4'h5 && op <= 4'hB) begin
          r_d[rd] = res;
          z_d     = (res == 16'h0000);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      r_q     <= r_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  // Memory is deliberately not reset so preloaded programs survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_a] <= a;
  end

`ifdef CPU_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst && state_q == EXEC) begin
      $display("PC=%0d IR=%b R0=%0d R1=%0d R2=%0d R3=%0d Z=%b C=%b",
               pc_q - 1'b1, ir_q, r_q[0], r_q[1], r_q[2], r_q[3], z_q, c_q);
      if (op == 4'hF) $display("HALT");
    end
  end
`endif

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: an instruction-level reference model predicts architectural
// state; a monitor pops expectations and compares against the core when asked to sample.
module tb_cpu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic halted;

  always #5 clk = ~clk;

  cpu #(.MEMORY_SIZE(32)) dut (.clk(clk), .rst(rst), .halted(halted));

  // kind: 0..3 register, 4 z, 5 c, 6 pc, 7 halted, 8 mem[addr]
  typedef struct {
    int          kind;
    int          addr;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] prog_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int req_cnt  = 0;
  int done_cnt = 0;

  // ---------------- reference model (instruction granularity) ----------------
  logic [15:0] m_mem [32];
  logic [15:0] m_r   [4];
  logic        m_z, m_c, m_h;
  int          m_pc;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 16'h0;
    m_z = 1'b0; m_c = 1'b0; m_h = 1'b0; m_pc = 0;
  endfunction

  function automatic void model_step();
    logic [15:0] ins;
    int op, rd, rs, imm, a, b, res;
    bit wr;
    if (m_h) return;
    ins  = m_mem[m_pc];
    m_pc = (m_pc + 1) % 32;
    op = int'(ins[15:12]); rd = int'(ins[11:10]); rs = int'(ins[9:8]); imm = int'(ins[7:0]);
    a = int'(m_r[rd]); b = int'(m_r[rs]); res = 0; wr = 1'b0;
    case (op)
      1:  m_r[rd] = 16'(imm);
      2:  begin m_r[rd] = m_mem[imm % 32]; m_z = (m_r[rd] == 16'h0); end
      3:  m_mem[imm % 32] = 16'(a);
      4:  m_r[rd] = 16'(b);
      5:  begin res = a + b; m_c = (res > 65535); res = res % 65536; wr = 1'b1; end
      6:  begin m_c = (a < b); res = (a - b + 65536) % 65536; wr = 1'b1; end
      7:  begin res = a & b; wr = 1'b1; end
      8:  begin res = a | b; wr = 1'b1; end
      9:  begin res = a ^ b; wr = 1'b1; end
      10: begin m_c = (a >= 32768); res = (a * 2) % 65536; wr = 1'b1; end
      11: begin m_c = ((a % 2) == 1); res = a / 2; wr = 1'b1; end
      12: m_pc = imm % 32;
      13: if (m_z) m_pc = imm % 32;
      14: if (!m_z) m_pc = imm % 32;
      15: m_h = 1'b1;
      default: ;
    endcase
    if (wr) begin m_r[rd] = 16'(res); m_z = (res == 0); end
  endfunction

  function automatic logic [15:0] enc(int op, int rd, int rs, int imm);
    return 16'((op << 12) | (rd << 10) | (rs << 8) | (imm & 255));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load(input logic [15:0] fill);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic [15:0] w;
      w = (i < prog_q.size()) ? prog_q[i] : fill;
      dut.mem[i] = w;
      m_mem[i]   = w;
    end
  endtask

  task automatic poke(input int addr, input logic [15:0] v);
    dut.mem[addr] = v;
    m_mem[addr]   = v;
  endtask

  task automatic release_rst();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    for (int i = 0; i < n / 2; i++) model_step();
    #1;
  endtask

  task automatic expect_val(input int kind, input int addr, input logic [15:0] v, input string name);
    exp_t e;
    e.kind = kind; e.addr = addr; e.exp = v; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic expect_model(input string tag, input bit with_mem);
    for (int i = 0; i < 4; i++) expect_val(i, 0, m_r[i], $sformatf("%s.r%0d", tag, i));
    expect_val(4, 0, {15'b0, m_z}, {tag, ".z"});
    expect_val(5, 0, {15'b0, m_c}, {tag, ".c"});
    expect_val(6, 0, 16'(m_pc), {tag, ".pc"});
    expect_val(7, 0, {15'b0, m_h}, {tag, ".halted"});
    if (with_mem)
      for (int i = 0; i < 32; i++) expect_val(8, i, m_mem[i], $sformatf("%s.mem%0d", tag, i));
  endtask

  task automatic sample();
    bit ok;
    ok = 1'b0;
    req_cnt++;
    for (int i = 0; i < 50; i++) begin
      if (done_cnt == req_cnt) begin ok = 1'b1; break; end
      #1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL monitor_timeout: done=%0d required=%0d", done_cnt, req_cnt);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  function automatic logic [15:0] actual(int kind, int addr);
    case (kind)
      0, 1, 2, 3: return dut.r_q[kind];
      4:          return {15'b0, dut.z_q};
      5:          return {15'b0, dut.c_q};
      6:          return 16'(dut.pc_q);
      7:          return {15'b0, halted};
      default:    return dut.mem[addr];
    endcase
  endfunction

  initial begin
    forever begin
      wait (req_cnt != done_cnt);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [15:0] act;
        e   = exp_q.pop_front();
        act = actual(e.kind, e.addr);
        n_checks++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
      done_cnt = req_cnt;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    expect_model("por", 1'b0);
    sample();

    // LDI/ADD/ST then HALT
    prog_q = '{enc(1,0,0,5), enc(1,1,0,7), enc(5,0,1,0), enc(3,0,0,20), enc(15,0,0,0)};
    load(16'h0000);
    release_rst();
    run(8);
    expect_val(7, 0, 16'h0, "add.not_yet_halted");
    sample();
    run(2);
    expect_val(8, 20, 16'd12, "add.mem20");
    expect_val(7, 0, 16'h1, "add.halted");
    expect_val(4, 0, 16'h0, "add.z");
    expect_val(5, 0, 16'h0, "add.c");
    expect_model("add", 1'b1);
    sample();

    // SUB and borrow
    prog_q = '{enc(1,0,0,3), enc(1,1,0,3), enc(6,0,1,0), enc(6,0,1,0), enc(15,0,0,0)};
    load(16'h0000);
    release_rst();
    run(6);
    expect_val(0, 0, 16'h0, "sub1.r0");
    expect_val(4, 0, 16'h1, "sub1.z");
    expect_val(5, 0, 16'h0, "sub1.c");
    sample();
    run(2);
    expect_val(0, 0, 16'hFFFD, "sub2.r0");
    expect_val(5, 0, 16'h1, "sub2.c");
    expect_val(4, 0, 16'h0, "sub2.z");
    expect_model("sub2", 1'b0);
    sample();

    // Countdown loop
    prog_q = '{enc(1,0,0,4), enc(1,1,0,1), enc(6,0,1,0), enc(14,0,0,2), enc(3,0,0,30), enc(15,0,0,0)};
    load(16'h0000);
    poke(30, 16'hAAAA);
    release_rst();
    run(22);
    expect_val(7, 0, 16'h0, "loop.running");
    sample();
    run(2);
    expect_val(7, 0, 16'h1, "loop.halted");
    expect_val(8, 30, 16'h0, "loop.mem30");
    expect_model("loop", 1'b1);
    sample();

    // PC wrap over an all-NOP memory
    prog_q = {};
    load(16'h0000);
    release_rst();
    run(62);
    expect_val(6, 0, 16'd31, "wrap.pc31");
    sample();
    run(2);
    expect_val(6, 0, 16'd0, "wrap.pc0");
    expect_val(7, 0, 16'h0, "wrap.no_halt");
    expect_model("wrap", 1'b0);
    sample();

    // Jump target truncation
    prog_q = '{enc(12,0,0,33)};
    load(16'h0000);
    release_rst();
    run(2);
    expect_val(6, 0, 16'd1, "jmp33.pc");
    sample();

    // Shifts and XOR
    prog_q = '{enc(1,0,0,8'h81)};
    for (int i = 0; i < 8; i++) prog_q.push_back(enc(10,0,0,0));
    prog_q.push_back(enc(11,0,0,0));
    prog_q.push_back(enc(9,0,0,0));
    prog_q.push_back(enc(15,0,0,0));
    load(16'h0000);
    release_rst();
    run(18);
    expect_val(0, 0, 16'h8100, "shl.r0");
    sample();
    run(2);
    expect_val(0, 0, 16'h4080, "shr.r0");
    expect_val(5, 0, 16'h0, "shr.c");
    sample();
    run(2);
    expect_val(0, 0, 16'h0, "xor.r0");
    expect_val(4, 0, 16'h1, "xor.z");
    sample();
    run(2);
    expect_model("shift", 1'b1);
    sample();

    // Reset mid-instruction: ST is in EXEC when reset arrives
    prog_q = '{enc(1,0,0,9), enc(3,0,0,25), enc(15,0,0,0)};
    load(16'h0000);
    poke(25, 16'h1234);
    release_rst();
    run(3);
    #1 rst = 1'b0;
    model_reset();
    #10;
    expect_val(8, 25, 16'h1234, "rst.no_store");
    expect_val(6, 0, 16'h0, "rst.pc");
    expect_model("rst", 1'b1);
    sample();
    release_rst();
    run(6);
    expect_val(8, 25, 16'd9, "rst.rerun_store");
    expect_model("rst_rerun", 1'b1);
    sample();

    // Randomized programs
    for (int t = 0; t < 15; t++) begin
      prog_q = {};
      for (int i = 0; i < 32; i++) begin
        int op;
        op = ($urandom_range(0, 19) == 0) ? 15 : int'($urandom_range(0, 14));
        prog_q.push_back(enc(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                             int'($urandom_range(0, 255))));
      end
      load(16'h0000);
      release_rst();
      run(2 * int'($urandom_range(5, 40)));
      expect_model($sformatf("rand%0d", t), 1'b1);
      sample();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
